// File: rtl/mem_arbiter_axil.sv
// Two-port arbiter sharing one memory-system wrapper request port between
// instruction fetch (read-only) and load/store (read/write), with fetch anti-starvation.
module mem_arbiter_axil #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  input  logic            i_kill,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_wr,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_be,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_done,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_data_in,
  output logic            m_wr,
  output logic            m_rd,
  output logic            m_valid,
  output logic [3:0]      m_be,
  input  logic [XLEN-1:0] m_data_out,
  input  logic            m_done,
  output logic            gnt_i,
  output logic            gnt_d
);

  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          kill_pend;
  logic [SW-1:0] streak_inc;
  logic          starved;
  logic          i_cmpl;
  logic          d_cmpl;

  assign starved    = (streak == SW'(STARVE_LIMIT));
  assign streak_inc = starved ? streak : streak + SW'(1);

  // Arbitration, request latching and completion; m_* are the latched request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      kill_pend <= 1'b0;
      m_valid   <= 1'b0;
      m_rd      <= 1'b0;
      m_wr      <= 1'b0;
      m_be      <= 4'h0;
      m_addr    <= '0;
      m_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && (!d_req || starved)) begin
            state     <= BUSY_I;
            streak    <= '0;
            m_valid   <= 1'b1;
            m_rd      <= 1'b1;
            m_wr      <= 1'b0;
            m_be      <= 4'hF;
            m_addr    <= i_addr;
            m_data_in <= '0;
          end else if (d_req) begin
            state     <= BUSY_D;
            streak    <= i_req ? streak_inc : '0;
            m_valid   <= 1'b1;
            m_rd      <= ~d_wr;
            m_wr      <= d_wr;
            m_be      <= d_be;
            m_addr    <= d_addr;
            m_data_in <= d_wdata;
          end else begin
            streak <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (m_done) begin
            state     <= IDLE;
            kill_pend <= 1'b0;
            m_valid   <= 1'b0;
            m_rd      <= 1'b0;
            m_wr      <= 1'b0;
            m_be      <= 4'h0;
            m_addr    <= '0;
            m_data_in <= '0;
          end else if (state == BUSY_I && i_kill) begin
            kill_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_i = (state == BUSY_I);
  assign gnt_d = (state == BUSY_D);

  // Completion is reported in the wrapper's done cycle; a killed fetch stays silent
  assign i_cmpl  = gnt_i & m_done;
  assign d_cmpl  = gnt_d & m_done;
  assign i_done  = i_cmpl & ~(kill_pend | i_kill);
  assign d_done  = d_cmpl;
  assign i_rdata = i_cmpl ? m_data_out : '0;
  assign d_rdata = d_cmpl ? m_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter_axil.sv
// Directed bench for mem_arbiter_axil: fetch, store, contention/starvation,
// kill, mid-transaction reset and request stability.
module tb_mem_arbiter_axil;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_kill;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [31:0] m_addr;
  logic [31:0] m_data_in;
  logic        m_wr;
  logic        m_rd;
  logic        m_valid;
  logic [3:0]  m_be;
  logic [31:0] m_data_out;
  logic        m_done;
  logic        gnt_i;
  logic        gnt_d;

  int total = 0;
  int bad   = 0;

  mem_arbiter_axil #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_wr(m_wr), .m_rd(m_rd), .m_valid(m_valid),
    .m_be(m_be), .m_data_out(m_data_out), .m_done(m_done),
    .gnt_i(gnt_i), .gnt_d(gnt_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    logic is_i;
    rst_n = 1'b0; i_req = 1'b0; i_addr = '0; i_kill = 1'b0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_be = 4'h0;
    m_data_out = '0; m_done = 1'b0;

    // Reset state
    nx(); #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_gnt", 32'({gnt_i, gnt_d}), 32'd0);
    chk("rst_done", 32'({i_done, d_done}), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    nx(); rst_n = 1'b1;

    // Fetch only, wrapper answers on the third busy cycle
    nx(); i_req = 1'b1; i_addr = 32'h0001_0000; #1;
    chk("f_t0_valid", 32'(m_valid), 32'd0);
    nx(); #1;
    chk("f_valid", 32'(m_valid), 32'd1);
    chk("f_rd_wr", 32'({m_rd, m_wr}), 32'b10);
    chk("f_be", 32'(m_be), 32'hF);
    chk("f_addr", m_addr, 32'h0001_0000);
    chk("f_data_in", m_data_in, 32'd0);
    chk("f_gnt", 32'({gnt_i, gnt_d}), 32'b10);
    chk("f_wait_done", 32'(i_done), 32'd0);
    nx(); #1;
    chk("f_wait2_valid", 32'(m_valid), 32'd1);
    nx(); m_done = 1'b1; m_data_out = 32'h0000_0013; #1;
    chk("f_done", 32'(i_done), 32'd1);
    chk("f_rdata", i_rdata, 32'h0000_0013);
    chk("f_d_done", 32'(d_done), 32'd0);
    nx(); m_done = 1'b0; i_req = 1'b0; #1;
    chk("f_bubble_valid", 32'(m_valid), 32'd0);
    chk("f_bubble_done", 32'(i_done), 32'd0);
    chk("f_bubble_rdata", i_rdata, 32'd0);

    // Store, with d_addr changed mid-transaction
    nx(); d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0001_0100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011; #1;
    nx(); #1;
    chk("s_rd_wr", 32'({m_rd, m_wr}), 32'b01);
    chk("s_data_in", m_data_in, 32'hDEAD_BEEF);
    chk("s_be", 32'(m_be), 32'h3);
    chk("s_addr", m_addr, 32'h0001_0100);
    chk("s_gnt", 32'({gnt_i, gnt_d}), 32'b01);
    nx(); d_addr = 32'h0000_0BAD; d_wdata = 32'h1234_5678; #1;
    chk("s_stable_addr", m_addr, 32'h0001_0100);
    chk("s_stable_data", m_data_in, 32'hDEAD_BEEF);
    nx(); m_done = 1'b1; m_data_out = 32'h5555_AAAA; #1;
    chk("s_done", 32'(d_done), 32'd1);
    chk("s_i_done", 32'(i_done), 32'd0);
    chk("s_rdata", d_rdata, 32'h5555_AAAA);
    nx(); m_done = 1'b0; d_req = 1'b0; d_wr = 1'b0; #1;
    chk("s_bubble", 32'({m_valid, d_done}), 32'd0);

    // Spurious m_done while idle
    nx(); m_done = 1'b1; #1;
    chk("sp_done", 32'({i_done, d_done}), 32'd0);
    chk("sp_valid", 32'(m_valid), 32'd0);
    nx(); m_done = 1'b0; #1;
    chk("sp_idle", 32'({gnt_i, gnt_d}), 32'd0);

    // Contention: expected grants D,D,D,D,I,D,D,D,D,I
    nx(); i_req = 1'b1; i_addr = 32'h0001_0200; d_req = 1'b1; d_addr = 32'h0001_0300; #1;
    for (int g = 0; g < 10; g++) begin
      is_i = (g == 4) || (g == 9);
      chk("c_idle_valid", 32'(m_valid), 32'd0);
      if (is_i) chk("c_streak", 32'(dut.streak), 32'd4);
      nx(); #1;
      chk("c_gnt", 32'({gnt_i, gnt_d}), is_i ? 32'b10 : 32'b01);
      m_done = 1'b1; m_data_out = 32'(g); #1;
      chk("c_done", 32'({i_done, d_done}), is_i ? 32'b10 : 32'b01);
      nx(); m_done = 1'b0; #1;
    end
    i_req = 1'b0; d_req = 1'b0; #1;

    // Kill one cycle before m_done, then a clean fetch
    nx(); i_req = 1'b1; i_addr = 32'h0001_0000; #1;
    nx(); #1;
    chk("k_gnt", 32'(gnt_i), 32'd1);
    nx(); i_kill = 1'b1; #1;
    chk("k_kill_cycle", 32'(i_done), 32'd0);
    nx(); i_kill = 1'b0; m_done = 1'b1; m_data_out = 32'h0000_0077; #1;
    chk("k_suppressed", 32'(i_done), 32'd0);
    chk("k_bus_valid", 32'(m_valid), 32'd1);
    nx(); m_done = 1'b0; i_addr = 32'h0001_0040; #1;
    chk("k_idle", 32'({m_valid, gnt_i}), 32'd0);
    nx(); #1;
    chk("k2_addr", m_addr, 32'h0001_0040);
    nx(); m_done = 1'b1; m_data_out = 32'h0000_0ABC; #1;
    chk("k2_done", 32'(i_done), 32'd1);
    chk("k2_rdata", i_rdata, 32'h0000_0ABC);
    nx(); m_done = 1'b0; #1;
    // Kill coincident with m_done
    nx(); #1;
    chk("kc_gnt", 32'(gnt_i), 32'd1);
    nx(); i_kill = 1'b1; m_done = 1'b1; #1;
    chk("kc_done", 32'(i_done), 32'd0);
    nx(); i_kill = 1'b0; m_done = 1'b0; i_req = 1'b0; #1;
    chk("kc_idle", 32'({m_valid, gnt_i}), 32'd0);

    // i_kill during a data transaction is ignored; the next fetch completes
    nx(); d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0001_0400; #1;
    nx(); i_kill = 1'b1; #1;
    nx(); i_kill = 1'b0; m_done = 1'b1; m_data_out = 32'h0000_0D0D; #1;
    chk("kd_d_done", 32'(d_done), 32'd1);
    nx(); m_done = 1'b0; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0001_0080; #1;
    nx(); #1;
    chk("kd_gnt_i", 32'(gnt_i), 32'd1);
    nx(); m_done = 1'b1; #1;
    chk("kd_i_done", 32'(i_done), 32'd1);
    nx(); m_done = 1'b0; i_req = 1'b0; #1;

    // Reset during BUSY_D, d_req held through release
    nx(); d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0001_0500; d_be = 4'hF; #1;
    nx(); #1;
    chk("r_busy", 32'({m_valid, gnt_d, m_rd}), 32'b111);
    nx(); rst_n = 1'b0; #1;
    chk("r_valid", 32'(m_valid), 32'd0);
    chk("r_gnt", 32'({gnt_i, gnt_d}), 32'd0);
    chk("r_addr", m_addr, 32'd0);
    chk("r_ctrl", 32'({m_rd, m_wr, m_be}), 32'd0);
    nx(); rst_n = 1'b1; #1;
    chk("r_idle", 32'(m_valid), 32'd0);
    nx(); #1;
    chk("r_regrant", 32'({m_valid, gnt_d}), 32'b11);
    chk("r_regrant_addr", m_addr, 32'h0001_0500);
    nx(); m_done = 1'b1; m_data_out = 32'hCAFE_F00D; #1;
    chk("r_done", 32'(d_done), 32'd1);
    chk("r_rdata", d_rdata, 32'hCAFE_F00D);
    nx(); m_done = 1'b0; d_req = 1'b0; #1;
    chk("r_after", 32'({d_done, gnt_d}), 32'd0);
    nx(); #1;
    chk("r_quiet", 32'({m_valid, d_done}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
